demux1to4_stream: RTL and testbench



---
 rtl/demux1to4_stream.sv | 108 ++++++++++
 tb/tb_demux1to4_stream.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/demux1to4_stream.sv
// demux1to4_stream
//    Registered 1-to-4 stream demultiplexer. Each accepted input word is
//    routed by i_sel into one of four independent 2-entry queues, and each
//    queue has its own valid/ready handshake. The queues decouple the
//    backpressure of the four consumers from each other.
//
// Ports
//    i_clk    clock, rising edge
//    i_rst    synchronous active-high reset
//    i_data   input word (W bits)
//    i_sel    destination channel 0..3, qualified by i_valid
//    i_valid  input word present
//    o_ready  input accepted when i_valid & o_ready
//    o_data   channel n data on [n*W +: W]
//    o_valid  per-channel output valid
//    i_ready  per-channel consumer ready
//    o_level  channel n occupancy (0..2) on [2n +: 2]
//
// Per-channel count states
//    state | meaning
//    EMPTY | no word queued, o_valid low
//    ONE   | one word queued, push and pop both allowed
//    FULL  | two words queued, pushes to this channel stalled
module demux1to4_stream #(
   parameter int W = 8
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic [W-1:0]   i_data,
   input  logic [1:0]     i_sel,
   input  logic           i_valid,
   output logic           o_ready,
   output logic [4*W-1:0] o_data,
   output logic [3:0]     o_valid,
   input  logic [3:0]     i_ready,
   output logic [7:0]     o_level
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } count_t;

   count_t count [4];

   // Readiness depends only on the selected channel's registered count, so
   // a pop on a full channel frees it one cycle later (no ready pass-through).
   assign o_ready = (count[i_sel] != FULL);

   for (genvar n = 0; n < 4; n++) begin : g_chan
      logic [W-1:0] mem [2];
      logic         wr_ptr;
      logic         rd_ptr;
      logic         push;
      logic         pop;

      assign push = i_valid & o_ready & (i_sel == 2'(n));
      assign pop  = o_valid[n] & i_ready[n];

      assign o_valid[n]          = (count[n] != EMPTY);
      assign o_data[n*W +: W]    = mem[rd_ptr];
      assign o_level[2*n +: 2]   = count[n];

      // Storage carries no reset; a word is only visible once counted.
      always_ff @(posedge i_clk) begin
         if (push && !i_rst) begin
            mem[wr_ptr] <= i_data;
         end
      end

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            count[n] <= EMPTY;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
         end else begin
            if (push) begin
               wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
               rd_ptr <= ~rd_ptr;
            end
            case (count[n])
               EMPTY: begin
                  if (push) begin
                     count[n] <= ONE;
                  end
               end
               ONE: begin
                  if (push && !pop) begin
                     count[n] <= FULL;
                  end else if (pop && !push) begin
                     count[n] <= EMPTY;
                  end
               end
               FULL: begin
                  if (pop) begin
                     count[n] <= ONE;
                  end
               end
               default: count[n] <= EMPTY;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_demux1to4_stream.sv
module tb_demux1to4_stream;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [7:0]  i_data;
   logic [1:0]  i_sel;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] o_data;
   logic [3:0]  o_valid;
   logic [3:0]  i_ready;
   logic [7:0]  o_level;

   int checks = 0;
   int errors = 0;

   // Reference model: one queue of words per channel, capacity two.
   logic [7:0] q [4][$];

   demux1to4_stream #(.W(8)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_data  (i_data),
      .i_sel   (i_sel),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .o_data  (o_data),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_level (o_level)
   );

   always #5 i_clk = ~i_clk;

   // Advance one clock edge and apply the same edge to the model.
   task automatic tick();
      logic [3:0] pop;
      logic       push;
      @(posedge i_clk);
      if (i_rst) begin
         for (int n = 0; n < 4; n++) q[n].delete();
      end else begin
         push = i_valid && (q[i_sel].size() < 2);
         for (int n = 0; n < 4; n++) pop[n] = (q[n].size() > 0) && i_ready[n];
         for (int n = 0; n < 4; n++) if (pop[n]) void'(q[n].pop_front());
         if (push) q[i_sel].push_back(i_data);
      end
      #1;
   endtask

   task automatic push_word(input logic [1:0] sel, input logic [7:0] d);
      i_valid = 1'b1; i_sel = sel; i_data = d;
      tick();
      i_valid = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_valid = 1'b1; i_sel = 2'd1; i_data = 8'hEE; i_ready = 4'h0;
      tick();
      tick();
      i_rst = 1'b0; i_valid = 1'b0;
      #1;
      checks++; if (o_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b exp 0000", o_valid); end
      checks++; if (o_level !== 8'h00) begin errors++; $display("FAIL reset_level got %h exp 00", o_level); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_ready); end
      tick();
      checks++; if (o_valid !== 4'b0000) begin errors++; $display("FAIL reset_idle_valid got %b exp 0000", o_valid); end
   endtask

   task automatic test_single_route();
      i_ready = 4'hF;
      push_word(2'd2, 8'hA5);
      checks++; if (o_valid !== 4'b0100) begin errors++; $display("FAIL route_valid got %b exp 0100", o_valid); end
      checks++; if (o_data[23:16] !== 8'hA5) begin errors++; $display("FAIL route_data got %h exp a5", o_data[23:16]); end
      tick();
      checks++; if (o_valid !== 4'b0000) begin errors++; $display("FAIL route_after got %b exp 0000", o_valid); end
   endtask

   task automatic test_fill_backpressure();
      i_ready = 4'b1101;
      push_word(2'd1, 8'h11);
      push_word(2'd1, 8'h22);
      i_valid = 1'b1; i_sel = 2'd1; i_data = 8'h33;
      #1;
      checks++; if (o_level[3:2] !== 2'd2) begin errors++; $display("FAIL fill_level got %0d exp 2", o_level[3:2]); end
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", o_ready); end
      tick();
      i_ready = 4'b1111;
      #1;
      checks++; if (o_data[15:8] !== 8'h11) begin errors++; $display("FAIL fill_first got %h exp 11", o_data[15:8]); end
      tick();
      checks++; if (o_level[3:2] !== 2'd1) begin errors++; $display("FAIL fill_bubble_level got %0d exp 1", o_level[3:2]); end
      checks++; if (o_data[15:8] !== 8'h22) begin errors++; $display("FAIL fill_second got %h exp 22", o_data[15:8]); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL fill_reopen got %b exp 1", o_ready); end
      tick();
      i_valid = 1'b0;
      checks++; if (o_data[15:8] !== 8'h33 || o_valid[1] !== 1'b1) begin errors++; $display("FAIL fill_third got %h/%b exp 33/1", o_data[15:8], o_valid[1]); end
      tick();
      checks++; if (o_level !== 8'h00) begin errors++; $display("FAIL fill_drained got %h exp 00", o_level); end
   endtask

   task automatic test_isolation();
      i_ready = 4'b1110;
      push_word(2'd0, 8'h01);
      push_word(2'd0, 8'h02);
      i_valid = 1'b1; i_sel = 2'd3; i_data = 8'h44;
      #1;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL iso_ready got %b exp 1", o_ready); end
      tick();
      i_valid = 1'b0;
      checks++; if (o_valid[3] !== 1'b1 || o_data[31:24] !== 8'h44) begin errors++; $display("FAIL iso_ch3 got %b/%h exp 1/44", o_valid[3], o_data[31:24]); end
      checks++; if (o_level[1:0] !== 2'd2 || o_data[7:0] !== 8'h01) begin errors++; $display("FAIL iso_ch0 got %0d/%h exp 2/01", o_level[1:0], o_data[7:0]); end
      i_ready = 4'hF;
      tick(); tick(); tick();
      checks++; if (o_level !== 8'h00) begin errors++; $display("FAIL iso_drained got %h exp 00", o_level); end
   endtask

   task automatic test_push_pop_one();
      i_ready = 4'b0000;
      push_word(2'd2, 8'h55);
      i_ready = 4'b0100;
      i_valid = 1'b1; i_sel = 2'd2; i_data = 8'h66;
      #1;
      checks++; if (o_data[23:16] !== 8'h55) begin errors++; $display("FAIL pp_head got %h exp 55", o_data[23:16]); end
      tick();
      i_valid = 1'b0;
      checks++; if (o_level[5:4] !== 2'd1 || o_data[23:16] !== 8'h66) begin errors++; $display("FAIL pp_next got %0d/%h exp 1/66", o_level[5:4], o_data[23:16]); end
      tick();
      checks++; if (o_level !== 8'h00) begin errors++; $display("FAIL pp_drained got %h exp 00", o_level); end
   endtask

   task automatic test_mid_reset();
      i_ready = 4'b0000;
      push_word(2'd0, 8'hC0);
      push_word(2'd0, 8'hC1);
      push_word(2'd1, 8'hC2);
      push_word(2'd2, 8'hC3);
      push_word(2'd2, 8'hC4);
      checks++; if (o_level !== 8'h26) begin errors++; $display("FAIL mr_levels got %h exp 26", o_level); end
      i_rst = 1'b1; i_valid = 1'b1; i_sel = 2'd3; i_data = 8'hDD;
      tick();
      i_rst = 1'b0; i_valid = 1'b0;
      checks++; if (o_level !== 8'h00 || o_valid !== 4'b0000) begin errors++; $display("FAIL mr_cleared got %h/%b exp 00/0000", o_level, o_valid); end
      push_word(2'd0, 8'h77);
      checks++; if (o_valid !== 4'b0001 || o_data[7:0] !== 8'h77) begin errors++; $display("FAIL mr_first got %b/%h exp 0001/77", o_valid, o_data[7:0]); end
      i_ready = 4'hF;
      tick();
   endtask

   task automatic test_random();
      logic [3:0] exp_valid;
      logic [7:0] exp_level;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         i_rst   = ($urandom_range(0, 99) == 0);
         i_valid = $urandom_range(0, 3) != 0;
         i_sel   = 2'($urandom_range(0, 3));
         i_data  = 8'($urandom);
         i_ready = 4'($urandom);
         #1;
         for (int n = 0; n < 4; n++) begin
            exp_valid[n]       = q[n].size() > 0;
            exp_level[2*n +: 2] = 2'(q[n].size());
         end
         checks++; if (o_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, o_valid, exp_valid); end
         checks++; if (o_level !== exp_level) begin errors++; $display("FAIL rnd_level cyc %0d got %h exp %h", cyc, o_level, exp_level); end
         checks++; if (o_ready !== (q[i_sel].size() < 2)) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, o_ready, q[i_sel].size() < 2); end
         for (int n = 0; n < 4; n++) begin
            if (q[n].size() > 0) begin
               checks++;
               if (o_data[n*8 +: 8] !== q[n][0]) begin
                  errors++; $display("FAIL rnd_data cyc %0d ch %0d got %h exp %h", cyc, n, o_data[n*8 +: 8], q[n][0]);
               end
            end
         end
         tick();
      end
      i_rst = 1'b0; i_valid = 1'b0;
   endtask

   initial begin
      i_rst = 1'b1; i_valid = 1'b0; i_sel = 2'd0; i_data = 8'h00; i_ready = 4'h0;
      test_reset();
      test_single_route();
      test_fill_backpressure();
      test_isolation();
      test_push_pop_one();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
